// File: rtl/rr_mux_reg.sv
// Registered 2**S-to-1 channel mux with valid/ready handshakes on every side.
// Selection is either directed by ctrl or round-robin across valid channels.
module rr_mux_reg #(
  parameter int S = 2,
  parameter int T = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [S-1:0]          ctrl,
  input  logic [(2**S)*T-1:0]   in,
  input  logic [(2**S)-1:0]     in_valid,
  output logic [(2**S)-1:0]     in_ready,
  output logic [T-1:0]          out,
  output logic [S-1:0]          out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int N = 2**S;

  logic [T-1:0] out_q, out_d;
  logic [S-1:0] sel_q, sel_d;
  logic         vld_q, vld_d;
  logic [S-1:0] ptr_q, ptr_d;

  logic         load;
  logic         gnt_vld;
  logic [S-1:0] gnt_idx;
  logic [S-1:0] cand;

  assign load = !vld_q || out_ready;

  // Round-robin search walks ptr+N down to ptr+1 so the nearest candidate wins;
  // ptr+N wraps to ptr itself, letting a sole valid channel at ptr be re-granted.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (!mode) begin
      if (in_valid[ctrl]) begin
        gnt_vld = 1'b1;
        gnt_idx = ctrl;
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        cand = ptr_q + S'(k);
        if (in_valid[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_ready[i] = gnt_vld && load && !reset && (gnt_idx == S'(i));
    end
  end

  always_comb begin
    out_d = out_q;
    sel_d = sel_q;
    vld_d = vld_q;
    ptr_d = ptr_q;
    if (load) begin
      if (gnt_vld) begin
        out_d = in[int'(gnt_idx)*T +: T];
        sel_d = gnt_idx;
        vld_d = 1'b1;
        if (mode) ptr_d = gnt_idx;
      end else begin
        vld_d = 1'b0;
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      sel_q <= '0;
      vld_q <= 1'b0;
      ptr_q <= S'(N-1);
    end else begin
      out_q <= out_d;
      sel_q <= sel_d;
      vld_q <= vld_d;
      ptr_q <= ptr_d;
    end
  end

  assign out       = out_q;
  assign out_sel   = sel_q;
  assign out_valid = vld_q;

endmodule

// File: doc/rr_mux_reg.md
# rr_mux_reg

Registered, handshaked 2**S-to-1 multiplexer for T-bit channels in the routing library. It generalises the combinational select-driven mux with a valid/ready interface on every input and on the output, a single output register stage, and a second selection mode: round-robin arbitration across valid channels. It sits between several producers and one consumer where the selection must be either software-directed or fair.

## Interface

Parameters:
- S, 2: select width; channel count N = 2**S; S >= 1.
- T, 3: data width per channel; T >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = directed (channel chosen by ctrl), 1 = round-robin.
- ctrl  input  S  channel index used in directed mode; ignored in round-robin mode.
- in  input  N*T  packed channel data; channel i occupies in[i*T +: T].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational; at most one bit set.
- out  output  T  registered data of the accepted beat.
- out_sel  output  S  registered index of the channel that supplied out.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.

## Operation

- Per-channel transfer: in_valid[i] && in_ready[i] at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- load = !out_valid || out_ready. The register can take a new beat in any cycle where load is high.
- Grant selection, evaluated combinationally every cycle:
  - mode 0: grant = ctrl if in_valid[ctrl], else no grant.
  - mode 1: grant = first i with in_valid[i] in the search order ptr+1, ptr+2, ..., ptr+N (mod N). No grant if in_valid == 0.
- in_ready[grant] = load && !reset. All other in_ready bits are 0.
- On edge with load high:
  - If a grant exists: out <= in[grant*T +: T], out_sel <= grant, out_valid <= 1.
  - Otherwise: out_valid <= 0, and out and out_sel hold.
- On edge with load low: out, out_sel and out_valid hold. This is the backpressure case.
- ptr: an S-bit register holding the last round-robin grant. It updates to grant only on a mode-1 grant that is taken. Directed-mode grants do not move ptr.
- mode and ctrl may change in any cycle. Changes affect only the next selection and never the beat already held in the register.

## Timing

- Reset values: out = 0, out_sel = 0, out_valid = 0, ptr = N-1, so the first round-robin search starts at channel 0. in_ready = 0 while reset is high.
- Latency: one cycle from input transfer to out_valid. Full throughput of one beat per cycle when out_ready is held high.
- in_ready depends combinationally on in_valid, mode, ctrl, out_valid and out_ready. There is no path from in_ready back to in_valid.
- Simultaneous output and input transfer in the same cycle: the register is replaced, with no bubble.
- Wrap-around: from ptr = N-1 the search begins at channel 0.
- Sole-valid channel equal to ptr: it is reached last in the search and is still granted. This repeats every cycle.
- Reset mid-operation: a held beat is dropped, out_valid = 0 on the next cycle, and ptr returns to N-1. No input transfer occurs in a reset cycle.

## Test plan

Common setup: S=2, T=3, in = {3'd4,3'd3,3'd2,3'd1}, so channels 0..3 carry 1,2,3,4.

- Reset: hold reset 2 cycles with in_valid=4'b1111, mode=1, out_ready=1 -> in_ready=0, out_valid=0, out=0, out_sel=0. Release reset -> first beat out=1, out_sel=0.
- Directed mode: mode=0, ctrl=2, in_valid=4'b1111, out_ready=1 -> in_ready=4'b0100 every cycle, out=3, out_sel=2. Then ctrl=1 with in_valid=4'b1101 -> in_ready=0 and out_valid=0 one cycle later.
- Round-robin, all valid: mode=1, in_valid=4'b1111, out_ready=1 -> out_sel sequence 0,1,2,3,0 and out sequence 1,2,3,4,1 on consecutive cycles.
- Round-robin, sparse: in_valid=4'b1010 -> out_sel 1,3,1,3. Then in_valid=4'b0100 -> out_sel 2 every cycle.
- Backpressure: with out_valid=1 and out_sel=1, drop out_ready for 3 cycles -> out, out_sel and out_valid stable, in_ready=0, ptr unchanged. Raise out_ready -> next beat out_sel=2.
- Reset mid-operation: out_valid=1, out_ready=0, ptr=2, assert reset 1 cycle -> out_valid=0 next cycle. After release with in_valid=4'b1111 -> grant channel 0.
